// File: rtl/bnn_ctrl_if.sv
// ============================================================================
// Module      : bnn_ctrl_if
// Description : Host/core bundle for bnn_ctrl: row-byte load handshake,
//               start/status, image to the core, class scores and result.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bnn_ctrl_if #(
    parameter int IMG_ROWS  = 8,
    parameter int N_CLASSES = 10,
    parameter int SCORE_W   = 7
);
    logic                                  load_valid_i;
    logic [7:0]                            load_data_i;
    logic                                  load_ready_o;
    logic                                  start_i;
    logic                                  busy_o;
    logic                                  done_o;
    logic                                  trigger_o;
    logic [0:0][IMG_ROWS-1:0][7:0]         layer_o;
    logic [N_CLASSES-1:0][SCORE_W-1:0]     score_i;
    logic [$clog2(N_CLASSES)-1:0]          class_o;
    logic [SCORE_W-1:0]                    max_score_o;

    modport master (
        output load_valid_i, load_data_i, start_i, score_i,
        input  load_ready_o, busy_o, done_o, trigger_o, layer_o, class_o, max_score_o
    );

    modport slave (
        input  load_valid_i, load_data_i, start_i, score_i,
        output load_ready_o, busy_o, done_o, trigger_o, layer_o, class_o, max_score_o
    );
endinterface

`default_nettype wire

// File: rtl/bnn_ctrl.sv
// ============================================================================
// Module      : bnn_ctrl
// Description : Sequencer for the binarized-network core: loads an image,
//               waits a settle window, then scans class scores for argmax.
//               Capture trigger enabled by macro BNN_CTRL_TRIGGER_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bnn_ctrl #(
    parameter int IMG_ROWS      = 8,
    parameter int N_CLASSES     = 10,
    parameter int SCORE_W       = 7,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    bnn_ctrl_if.slave    bus
);

    localparam int c_ROW_W     = $clog2(IMG_ROWS + 1);
    localparam int c_ROW_IDX_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int c_IDX_W     = $clog2(N_CLASSES);

    localparam logic [c_ROW_W-1:0] c_LAST_ROW    = c_ROW_W'(IMG_ROWS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_K      = c_IDX_W'(N_CLASSES - 1);
    localparam logic [7:0]         c_SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SCAN   = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]                     r_state;
    logic [c_ROW_W-1:0]             r_row_cnt;
    logic                           r_full;
    logic [7:0]                     r_settle_cnt;
    logic [c_IDX_W-1:0]             r_k;
    logic [c_IDX_W-1:0]             r_best_idx;
    logic [SCORE_W-1:0]             r_best_score;
    logic [c_IDX_W-1:0]             r_class;
    logic [SCORE_W-1:0]             r_max;
    logic [0:0][IMG_ROWS-1:0][7:0]  r_layer;

    logic                           w_idle;
    logic                           w_load_ready;
    logic                           w_load_fire;
    logic                           w_start;
    logic [SCORE_W-1:0]             w_score_k;
    logic                           w_take;
    logic [c_IDX_W-1:0]             w_nidx;
    logic [SCORE_W-1:0]             w_nscore;

    assign w_idle       = (r_state == c_ST_IDLE);
    assign w_load_ready = w_idle && !r_full;
    assign w_load_fire  = w_load_ready && bus.load_valid_i;
    // full is the registered value, so a start alongside the last byte is ignored
    assign w_start      = w_idle && r_full && bus.start_i;

    // Strict compare keeps the lowest index on ties
    assign w_score_k = bus.score_i[r_k];
    assign w_take    = (r_k == '0) || (w_score_k > r_best_score);
    assign w_nidx    = w_take ? r_k       : r_best_idx;
    assign w_nscore  = w_take ? w_score_k : r_best_score;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= c_ST_IDLE;
            r_row_cnt    <= '0;
            r_full       <= 1'b0;
            r_settle_cnt <= '0;
            r_k          <= '0;
            r_best_idx   <= '0;
            r_best_score <= '0;
            r_class      <= '0;
            r_max        <= '0;
            r_layer      <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_load_fire) begin
                        r_layer[0][r_row_cnt[c_ROW_IDX_W-1:0]] <= bus.load_data_i;
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (r_row_cnt == c_LAST_ROW) begin
                            r_full <= 1'b1;
                        end
                    end
                    if (w_start) begin
                        r_state      <= c_ST_SETTLE;
                        r_settle_cnt <= c_SETTLE_INIT;
                    end
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state <= c_ST_SCAN;
                        r_k     <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                c_ST_SCAN: begin
                    r_best_idx   <= w_nidx;
                    r_best_score <= w_nscore;
                    // Result is registered on the final compare so it is valid during done_o
                    if (r_k == c_LAST_K) begin
                        r_state <= c_ST_DONE;
                        r_class <= w_nidx;
                        r_max   <= w_nscore;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    r_row_cnt <= '0;
                    r_full    <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready_o = w_load_ready;
    assign bus.busy_o       = !w_idle;
    assign bus.done_o       = (r_state == c_ST_DONE);
    assign bus.layer_o      = r_layer;
    assign bus.class_o      = r_class;
    assign bus.max_score_o  = r_max;

`ifdef BNN_CTRL_TRIGGER_EN
    assign bus.trigger_o = (r_state == c_ST_SETTLE);
`else
    assign bus.trigger_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bnn_ctrl.sv
// ============================================================================
// Module      : tb_bnn_ctrl
// Description : Randomized self-checking bench for bnn_ctrl against an
//               image/argmax reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bnn_ctrl;

    localparam int IMG_ROWS  = 8;
    localparam int N_CLASSES = 10;
    localparam int SCORE_W   = 7;
    localparam int SETTLE    = 4;
    localparam int DONE_LAT  = SETTLE + N_CLASSES + 1;
`ifdef BNN_CTRL_TRIGGER_EN
    localparam int EXP_TRIG  = SETTLE;
`else
    localparam int EXP_TRIG  = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bnn_ctrl_if #(.IMG_ROWS(IMG_ROWS), .N_CLASSES(N_CLASSES), .SCORE_W(SCORE_W)) bus();

    bnn_ctrl #(
        .IMG_ROWS      (IMG_ROWS),
        .N_CLASSES     (N_CLASSES),
        .SCORE_W       (SCORE_W),
        .SETTLE_CYCLES (SETTLE)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_img [IMG_ROWS];
    int         m_rows;
    int         m_cls;
    int         m_max;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_layer();
        logic [63:0] v = '0;
        for (int r = 0; r < IMG_ROWS; r++) v[r*8 +: 8] = m_img[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < IMG_ROWS; r++) m_img[r] = 8'h00;
        m_rows = 0;
        m_cls  = 0;
        m_max  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ready"}, 64'(bus.load_ready_o), 64'd1);
        check({tag, ".busy"},  64'(bus.busy_o),       64'd0);
        check({tag, ".done"},  64'(bus.done_o),       64'd0);
        check({tag, ".trig"},  64'(bus.trigger_o),    64'd0);
        check({tag, ".layer"}, 64'(bus.layer_o),      64'd0);
        check({tag, ".class"}, 64'(bus.class_o),      64'd0);
        check({tag, ".max"},   64'(bus.max_score_o),  64'd0);
    endtask

    task automatic load_row(input logic [7:0] b);
        check("load.ready", 64'(bus.load_ready_o), 64'd1);
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = b;
        tick();
        bus.load_valid_i = 1'b0;
        m_img[m_rows] = b;
        m_rows++;
    endtask

    task automatic load_random_image();
        for (int r = 0; r < IMG_ROWS; r++) load_row(8'($urandom));
        check("load.layer", 64'(bus.layer_o), model_layer());
    endtask

    // Start, then watch a fixed window; with poke set, a second start lands in
    // the settle window and load_valid is held during the scan.
    task automatic run(input int sc[N_CLASSES], input bit poke);
        int done_at = -1;
        int ndone = 0, ntrig = 0, nbusy = 0, nready_busy = 0;
        logic [63:0] lay = model_layer();
        for (int k = 0; k < N_CLASSES; k++) bus.score_i[k] = SCORE_W'(sc[k]);
        m_cls = 0;
        for (int k = 1; k < N_CLASSES; k++) if (sc[k] > sc[m_cls]) m_cls = k;
        m_max = sc[m_cls];
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (bus.done_o) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (bus.trigger_o) ntrig++;
            if (bus.busy_o) begin
                nbusy++;
                if (bus.load_ready_o) nready_busy++;
            end
            if (done_at == i) begin
                check("run.class_at_done", 64'(bus.class_o), 64'(m_cls));
                check("run.layer_at_done", 64'(bus.layer_o), lay);
            end
            bus.start_i      = poke && (i == 2);
            bus.load_valid_i = poke && (i >= 6) && (i <= 10);
            bus.load_data_i  = 8'($urandom);
            tick();
        end
        bus.start_i      = 1'b0;
        bus.load_valid_i = 1'b0;
        m_rows = 0;
        check("run.done_cycle", 64'(done_at), 64'(DONE_LAT));
        check("run.done_count", 64'(ndone), 64'd1);
        check("run.trig_cycles", 64'(ntrig), 64'(EXP_TRIG));
        check("run.busy_cycles", 64'(nbusy), 64'(DONE_LAT));
        check("run.ready_while_busy", 64'(nready_busy), 64'd0);
        check("run.layer", 64'(bus.layer_o), lay);
        check("run.class", 64'(bus.class_o), 64'(m_cls));
        check("run.max", 64'(bus.max_score_o), 64'(m_max));
        check("run.ready_after", 64'(bus.load_ready_o), 64'd1);
    endtask

    initial begin
        int sc [N_CLASSES];
        bus.load_valid_i = 1'b0;
        bus.load_data_i  = 8'h00;
        bus.start_i      = 1'b0;
        bus.score_i      = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Walking-one image, ascending scores
        for (int r = 0; r < IMG_ROWS; r++) load_row(8'(1 << r));
        check("walk.layer", 64'(bus.layer_o), model_layer());
        for (int k = 0; k < N_CLASSES; k++) sc[k] = k * 3;
        run(sc, 1'b0);
        check("walk.class9", 64'(bus.class_o), 64'd9);
        check("walk.max27", 64'(bus.max_score_o), 64'd27);

        // Tie between index 1 and 2, with busy-time pokes
        load_random_image();
        sc[0] = 5; sc[1] = 40; sc[2] = 40;
        for (int k = 3; k < N_CLASSES; k++) sc[k] = $urandom_range(0, 39);
        run(sc, 1'b1);
        check("tie.class", 64'(bus.class_o), 64'd1);
        check("tie.max", 64'(bus.max_score_o), 64'd40);

        // Start with a partial image, then start together with the last byte
        for (int r = 0; r < IMG_ROWS - 1; r++) load_row(8'($urandom));
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("partial.busy", 64'(bus.busy_o), 64'd0);
            tick();
        end
        bus.load_valid_i = 1'b1;
        bus.load_data_i  = 8'($urandom);
        bus.start_i      = 1'b1;
        m_img[m_rows] = bus.load_data_i;
        m_rows++;
        tick();
        bus.load_valid_i = 1'b0;
        bus.start_i      = 1'b0;
        check("laststart.busy", 64'(bus.busy_o), 64'd0);
        check("laststart.ready", 64'(bus.load_ready_o), 64'd0);
        check("laststart.layer", 64'(bus.layer_o), model_layer());
        tick();
        check("laststart.busy2", 64'(bus.busy_o), 64'd0);
        for (int k = 0; k < N_CLASSES; k++) sc[k] = $urandom_range(0, 127);
        run(sc, 1'b0);

        // Randomized images and scores; narrow ranges force ties
        for (int it = 0; it < 6; it++) begin
            load_random_image();
            for (int k = 0; k < N_CLASSES; k++)
                sc[k] = (it % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 127);
            run(sc, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of an image load
        for (int r = 0; r < 3; r++) load_row(8'($urandom));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_load");
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a scan
        load_random_image();
        for (int k = 0; k < N_CLASSES; k++) bus.score_i[k] = SCORE_W'($urandom);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (6) tick();
        check("rst_scan.busy_before", 64'(bus.busy_o), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("rst_scan");
        repeat (3) tick();
        check("rst_scan.no_done", 64'(bus.done_o), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();

        // After reset a fresh image starts at row 0
        load_random_image();
        for (int k = 0; k < N_CLASSES; k++) sc[k] = $urandom_range(0, 127);
        run(sc, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
